// File: rtl/trace_pkg.sv
// Shared types for the retirement trace transmitter: record layout, packet tag,
// serializer states and the word/last selection used by the output stage.
package trace_pkg;

    localparam logic [7:0] TRACE_TAG = 8'hA5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        rd_v;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        mem_v;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [7:0]  seq;
        logic [7:0]  drops;
    } trace_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PC,
        ST_INSTR,
        ST_RD,
        ST_MADDR,
        ST_MDATA
    } tx_state_e;

    function automatic logic [31:0] pkt_word(input tx_state_e s, input trace_rec_t r);
        logic [31:0] w;
        case (s)
            ST_HDR:   w = {TRACE_TAG, r.seq, r.rd_v, r.mem_v, (r.drops != 8'd0), r.rd_addr, r.drops};
            ST_PC:    w = r.pc;
            ST_INSTR: w = r.instr;
            ST_RD:    w = r.rd_data;
            ST_MADDR: w = r.mem_addr;
            ST_MDATA: w = r.mem_wdata;
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic logic pkt_last(input tx_state_e s, input trace_rec_t r);
        logic l;
        case (s)
            ST_INSTR: l = !r.rd_v && !r.mem_v;
            ST_RD:    l = !r.mem_v;
            ST_MDATA: l = 1'b1;
            default:  l = 1'b0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO with registered count/full/empty; the head record is visible
// combinationally so the serializer can load it in the same cycle it pops.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  trace_rec_t i_rec,
    input  logic       i_pop,
    output trace_rec_t o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    trace_rec_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d, empty_q, empty_d;
    logic            push_ok, pop_ok;

    always_comb begin
        push_ok  = i_push && !full_q;
        pop_ok   = i_pop && !empty_q;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        full_d   = (count_d == (AW + 1)'(DEPTH));
        empty_d  = (count_d == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= i_rec;
        end
    end

    assign o_head  = mem[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: captures one record per retire and streams it
// as a 3..6 word packet. Define TRACE_STALL_EN to drive o_stall from FIFO full.
module retire_trace_tx
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_retire_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_rd_we,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_rd_data,
    input  logic        i_mem_we,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic [31:0] o_tx_data,
    output logic        o_tx_last,
    output logic        o_stall
);
    trace_rec_t  rec_in, fifo_head, hold_q, hold_d;
    logic        fifo_full, fifo_empty, fifo_pop;
    logic [7:0]  seq_q, seq_d, drops_q, drops_d;
    tx_state_e   state_q, state_d;
    logic        tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        rd_v, dropped, fire, pkt_end;

    always_comb begin
        rd_v   = i_rd_we && (i_rd_addr != 5'd0);
        rec_in = '{pc: i_pc, instr: i_instr, rd_v: rd_v,
                   rd_addr: rd_v ? i_rd_addr : 5'd0, rd_data: i_rd_data,
                   mem_v: i_mem_we, mem_addr: i_mem_addr, mem_wdata: i_mem_wdata,
                   seq: seq_q, drops: drops_q};
        dropped = i_retire_valid && fifo_full;
        seq_d   = i_retire_valid ? seq_q + 8'd1 : seq_q;
        drops_d = drops_q;
        if (dropped) begin
            drops_d = (drops_q == 8'hFF) ? 8'hFF : drops_q + 8'd1;
        end else if (i_retire_valid) begin
            drops_d = 8'd0;
        end
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_retire_valid),
        .i_rec   (rec_in),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        fifo_pop = 1'b0;
        pkt_end  = 1'b0;
        fire     = tx_valid_q && i_tx_ready;
        case (state_q)
            // IDLE shares the end-of-packet path: load the head if one is waiting.
            ST_IDLE:  pkt_end = 1'b1;
            ST_HDR:   if (fire) state_d = ST_PC;
            ST_PC:    if (fire) state_d = ST_INSTR;
            ST_INSTR: if (fire) begin
                if (hold_q.rd_v)       state_d = ST_RD;
                else if (hold_q.mem_v) state_d = ST_MADDR;
                else                   pkt_end = 1'b1;
            end
            ST_RD:    if (fire) begin
                if (hold_q.mem_v) state_d = ST_MADDR;
                else              pkt_end = 1'b1;
            end
            ST_MADDR: if (fire) state_d = ST_MDATA;
            ST_MDATA: if (fire) pkt_end = 1'b1;
            default:  state_d = ST_IDLE;
        endcase
        if (pkt_end) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                hold_d   = fifo_head;
                state_d  = ST_HDR;
            end else begin
                state_d  = ST_IDLE;
            end
        end
        // Outputs are registered from the next state, so they stay put while stalled.
        tx_valid_d = (state_d != ST_IDLE);
        tx_data_d  = pkt_word(state_d, hold_d);
        tx_last_d  = pkt_last(state_d, hold_d);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            seq_q      <= 8'd0;
            drops_q    <= 8'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 32'd0;
            tx_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            seq_q      <= seq_d;
            drops_q    <= drops_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_last_q  <= tx_last_d;
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_last  = tx_last_q;

`ifdef TRACE_STALL_EN
    assign o_stall = fifo_full;
`else
    assign o_stall = 1'b0;
`endif

endmodule

// File: tb/tb_retire_trace_tx.sv
// Self-checking bench for retire_trace_tx: directed packet scenarios plus a
// randomized run against a queue-based packet model.
module tb_retire_trace_tx;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        retire_valid = 1'b0;
    logic [31:0] pc = '0, instr = '0, rd_data = '0, mem_addr = '0, mem_wdata = '0;
    logic        rd_we = 1'b0, mem_we = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        tx_valid, tx_last, stall;
    logic        tx_ready = 1'b0;
    logic [31:0] tx_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];
    int          pkts_done = 0;
    int          accepted = 0;
    int          stab_err = 0;
    logic        prev_stalled = 1'b0;
    logic [32:0] prev_word = '0;

    always #5 clk = ~clk;

    retire_trace_tx #(.DEPTH(DEPTH)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_retire_valid (retire_valid),
        .i_pc           (pc),
        .i_instr        (instr),
        .i_rd_we        (rd_we),
        .i_rd_addr      (rd_addr),
        .i_rd_data      (rd_data),
        .i_mem_we       (mem_we),
        .i_mem_addr     (mem_addr),
        .i_mem_wdata    (mem_wdata),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_tx_data      (tx_data),
        .o_tx_last      (tx_last),
        .o_stall        (stall)
    );

    // Stream monitor: logs every handshaked word and flags unstable stalled words.
    always @(negedge clk) begin
        if (rst) begin
            prev_stalled = 1'b0;
        end else begin
            if (prev_stalled && !(tx_valid && {tx_last, tx_data} === prev_word))
                stab_err++;
            if (tx_valid && tx_ready) begin
                got_q.push_back({tx_last, tx_data});
                $display("word %0d: data=%08h last=%0b", got_q.size() - 1, tx_data, tx_last);
                if (tx_last) pkts_done++;
            end
            prev_stalled = tx_valid && !tx_ready;
            prev_word    = {tx_last, tx_data};
        end
    end

    function automatic logic [31:0] model_hdr(input int seq, input bit rdv, input bit memv,
                                              input int rda, input int drops);
        logic [31:0] h;
        h = 32'hA500_0000;
        h = h + 32'((seq % 256) * 65536);
        if (rdv) h = h + 32'h8000 + 32'((rda % 32) * 256);
        if (memv) h = h + 32'h4000;
        if (drops != 0) h = h + 32'h2000;
        h = h + 32'(drops % 256);
        return h;
    endfunction

    task automatic model_packet(input logic [31:0] p, input logic [31:0] ins, input bit rdv,
                                input int rda, input logic [31:0] rdd, input bit memv,
                                input logic [31:0] ma, input logic [31:0] md, input int seq);
        exp_q.push_back({1'b0, model_hdr(seq, rdv, memv, rda, 0)});
        exp_q.push_back({1'b0, p});
        exp_q.push_back({!rdv && !memv, ins});
        if (rdv) exp_q.push_back({!memv, rdd});
        if (memv) begin
            exp_q.push_back({1'b0, ma});
            exp_q.push_back({1'b1, md});
        end
    endtask

    task automatic do_retire(input logic [31:0] p, input logic [31:0] ins, input logic rwe,
                             input logic [4:0] ra, input logic [31:0] rdd, input logic mwe,
                             input logic [31:0] ma, input logic [31:0] md);
        retire_valid = 1'b1;
        pc = p; instr = ins; rd_we = rwe; rd_addr = ra; rd_data = rdd;
        mem_we = mwe; mem_addr = ma; mem_wdata = md;
        @(posedge clk); #1;
        retire_valid = 1'b0;
        accepted++;
    endtask

    task automatic apply_reset();
        retire_valid = 1'b0;
        tx_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete(); exp_q.delete();
        pkts_done = 0; accepted = 0; stab_err = 0;
    endtask

    task automatic wait_got(input int n);
        for (int c = 0; c < 1000 && got_q.size() < n; c++) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; #2;
        n_total++; if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", tx_valid); else n_pass++;
        n_total++; if (tx_data !== 32'd0) $display("FAIL reset_data: got %08h want 0", tx_data); else n_pass++;
        n_total++; if (tx_last !== 1'b0) $display("FAIL reset_last: got %0b want 0", tx_last); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %0b want 0", stall); else n_pass++;
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        tx_ready = 1'b1;
        do_retire(32'h0, 32'h13, 1'b1, 5'd0, 32'h55, 1'b0, 32'h0, 32'h0);
        n_total++; if (tx_valid !== 1'b0) $display("FAIL single_latency0: valid got %0b want 0", tx_valid); else n_pass++;
        @(posedge clk); #1;
        n_total++; if ({tx_valid, tx_data} !== {1'b1, 32'hA500_0000})
            $display("FAIL single_latency1: got v=%0b d=%08h want v=1 d=a5000000", tx_valid, tx_data); else n_pass++;
        wait_got(3);
        n_total++; if (got_q.size() != 3) $display("FAIL single_len: got %0d want 3", got_q.size()); else n_pass++;
        if (got_q.size() == 3) begin
            n_total++; if (got_q[0] !== {1'b0, 32'hA500_0000}) $display("FAIL single_w0: got %09h want 0a5000000", got_q[0]); else n_pass++;
            n_total++; if (got_q[1] !== {1'b0, 32'h0}) $display("FAIL single_w1: got %09h want 000000000", got_q[1]); else n_pass++;
            n_total++; if (got_q[2] !== {1'b1, 32'h13}) $display("FAIL single_w2: got %09h want 100000013", got_q[2]); else n_pass++;
        end
    endtask

    task automatic test_full_packet();
        logic [32:0] want [6];
        apply_reset();
        tx_ready = 1'b1;
        want = '{{1'b0, 32'hA500_C500}, {1'b0, 32'h100}, {1'b0, 32'h0051_2023},
                 {1'b0, 32'h1234}, {1'b0, 32'h40}, {1'b1, 32'hDEAD_BEEF}};
        do_retire(32'h100, 32'h0051_2023, 1'b1, 5'd5, 32'h1234, 1'b1, 32'h40, 32'hDEAD_BEEF);
        wait_got(6);
        n_total++; if (got_q.size() != 6) $display("FAIL full_len: got %0d want 6", got_q.size()); else n_pass++;
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== want[i]) $display("FAIL full_w%0d: got %09h want %09h", i, got_q[i], want[i]); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        model_packet(32'h200, 32'h0002_A023, 1'b1, 7, 32'hCAFE_0001, 1'b1, 32'h80, 32'h1234_5678, 0);
        do_retire(32'h200, 32'h0002_A023, 1'b1, 5'd7, 32'hCAFE_0001, 1'b1, 32'h80, 32'h1234_5678);
        for (int c = 0; c < 20 && !tx_valid; c++) begin @(posedge clk); #1; end
        for (int i = 0; i < 4; i++) begin tx_ready = pat[i]; @(posedge clk); #1; end
        tx_ready = 1'b1;
        wait_got(6);
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL bp_len: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL bp_w%0d: got %09h want %09h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (stab_err != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", stab_err); else n_pass++;
    endtask

    task automatic test_overflow();
        logic exp_stall;
`ifdef TRACE_STALL_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            do_retire(32'(i * 4), 32'h13, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
            if (i == 4) begin
                n_total++; if (stall !== exp_stall) $display("FAIL ovf_stall: got %0b want %0b", stall, exp_stall); else n_pass++;
            end
        end
        tx_ready = 1'b1;
        wait_got(15);
        n_total++; if (got_q.size() != 15) $display("FAIL ovf_len: got %0d want 15", got_q.size()); else n_pass++;
        for (int i = 0; i < 5 && 3 * i + 2 < got_q.size(); i++) begin
            n_total++; if (got_q[3*i] !== {1'b0, model_hdr(i, 0, 0, 0, 0)})
                $display("FAIL ovf_hdr%0d: got %09h want %09h", i, got_q[3*i], {1'b0, model_hdr(i, 0, 0, 0, 0)}); else n_pass++;
            n_total++; if (got_q[3*i+2] !== {1'b1, 32'h13}) $display("FAIL ovf_last%0d: got %09h want 100000013", i, got_q[3*i+2]); else n_pass++;
        end
        do_retire(32'h1000, 32'h13, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_got(18);
        n_total++; if (got_q.size() != 18) $display("FAIL ovf_len2: got %0d want 18", got_q.size()); else n_pass++;
        if (got_q.size() == 18) begin
            n_total++; if (got_q[15] !== {1'b0, 32'hA507_2002}) $display("FAIL ovf_drop_hdr: got %09h want 0a5072002", got_q[15]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_retire(32'h300, 32'h13, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 20 && !tx_valid; c++) begin @(posedge clk); #1; end
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        n_total++; if (tx_data !== 32'h300) $display("FAIL mid_pc: got %08h want 00000300", tx_data); else n_pass++;
        @(posedge clk); #2;
        rst = 1'b1; #1;
        n_total++; if ({tx_valid, tx_last, stall, tx_data} !== 35'd0)
            $display("FAIL mid_async: got v=%0b l=%0b s=%0b d=%08h want all 0", tx_valid, tx_last, stall, tx_data); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        got_q.delete(); pkts_done = 0; accepted = 0; stab_err = 0;
        tx_ready = 1'b1;
        do_retire(32'h400, 32'h13, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0, 32'h0);
        wait_got(3);
        n_total++; if (got_q.size() != 3) $display("FAIL mid_len: got %0d want 3", got_q.size()); else n_pass++;
        if (got_q.size() >= 1) begin
            n_total++; if (got_q[0] !== {1'b0, 32'hA500_0000}) $display("FAIL mid_hdr: got %09h want 0a5000000", got_q[0]); else n_pass++;
        end
    endtask

    task automatic test_random();
        int seq_m = 0;
        apply_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tx_ready = ($urandom_range(9) < 7);
            if ((accepted - pkts_done) < DEPTH && $urandom_range(1) == 1) begin
                logic [31:0] p, ins, rdd, ma, md;
                logic        rwe, mwe;
                logic [4:0]  ra;
                p = $urandom; ins = $urandom; rdd = $urandom; ma = $urandom; md = $urandom;
                rwe = 1'($urandom_range(1)); mwe = 1'($urandom_range(1)); ra = 5'($urandom_range(31));
                model_packet(p, ins, rwe && (ra != 0), int'(ra), rdd, mwe, ma, md, seq_m);
                seq_m++;
                do_retire(p, ins, rwe, ra, rdd, mwe, ma, md);
            end else begin
                @(posedge clk); #1;
            end
        end
        tx_ready = 1'b1;
        wait_got(exp_q.size());
        n_total++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_len: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_total++; if (got_q[i] !== exp_q[i]) $display("FAIL rnd_w%0d: got %09h want %09h", i, got_q[i], exp_q[i]); else n_pass++;
        end
        n_total++; if (stab_err != 0) $display("FAIL rnd_stable: got %0d unstable cycles want 0", stab_err); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_packet();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/retire_trace_tx.md
# retire_trace_tx

- Transmit side of the core's retirement trace.
- Sits beside `singlecycle` and captures one record per retired instruction: PC, instruction word, register writeback and store.
- Buffers records in a small FIFO and serializes each as a variable-length packet of 32-bit words over a valid/ready stream.
- The consumer is a bench monitor or an on-chip UART/debug bridge, so architectural state is logged from inside the RTL instead of by hierarchical probing.

## Interface
- `DEPTH`, 4: FIFO depth in records; power of two, ≥2.
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_retire_valid`  in  1  one instruction retires this cycle.
- `i_pc`  in  32  PC of the retiring instruction.
- `i_instr`  in  32  instruction word.
- `i_rd_we`  in  1  register-file write enable.
- `i_rd_addr`  in  5  destination register.
- `i_rd_data`  in  32  writeback value.
- `i_mem_we`  in  1  store this instruction.
- `i_mem_addr`  in  32  store byte address.
- `i_mem_wdata`  in  32  store data after lane alignment.
- `o_tx_valid`  out  1  `o_tx_data` holds a valid word.
- `i_tx_ready`  in  1  consumer accepts the word.
- `o_tx_data`  out  32  packet word.
- `o_tx_last`  out  1  final word of the packet.
- `o_stall`  out  1  core must hold retirement (see Configuration).

## Operation
- **Capture:** on `i_retire_valid`, the record is built from the inputs and pushed if the FIFO is not full.
  - `rd_v = i_rd_we && i_rd_addr != 0`
  - `mem_v = i_mem_we`
- **Full FIFO:** the push is decided on the registered count. A push arriving when the FIFO is full is dropped, even if a pop occurs in the same cycle.
- **Sequence number:** `seq` is 8 bits. It increments on every retire, including dropped ones, and wraps 255→0. The record carries the pre-increment value.
- **Drop counter:** `drops` is 8 bits and saturates at 255.
  - Increments on each dropped retire.
  - Is copied into the next accepted record, then cleared.
  - If a retire is dropped in the same cycle that the counter is copied into a record, the counter becomes 1.
- **Packet word order:** HDR, PC, INSTR, [RD_DATA if rd_v], [MEM_ADDR, MEM_DATA if mem_v]. Length is 3 to 6 words.
- **HDR word fields:**
  - [31:24] = 8'hA5
  - [23:16] = seq
  - [15] = rd_v
  - [14] = mem_v
  - [13] = (drops≠0)
  - [12:8] = rd_addr (0 when !rd_v)
  - [7:0] = drops
- **Serializer FSM:** states IDLE, HDR, PC, INSTR, RD, MADDR, MDATA.
  - IDLE→HDR when the FIFO is non-empty; the head record is loaded into a holding register and popped.
  - Each word advances on `o_tx_valid && i_tx_ready`.
  - INSTR→RD if rd_v, else →MADDR if mem_v, else end.
  - RD→MADDR if mem_v, else end.
  - MADDR→MDATA; MDATA ends the packet.
  - At end of packet: →HDR if the FIFO is non-empty (head loaded), else →IDLE.
- **Stream rules:**
  - `o_tx_data` and `o_tx_last` are stable while `o_tx_valid && !i_tx_ready`.
  - `o_tx_valid` never drops without a handshake.
  - `o_tx_last` is asserted only on the final word.
- **Reset values:** `o_tx_valid`=0, `o_tx_data`=0, `o_tx_last`=0, `o_stall`=0. FIFO empty, FSM in IDLE, seq=0, drops=0.
- **Reset mid-packet:** the packet is abandoned with no `o_tx_last`. The first post-reset packet starts with HDR seq=0.

## Timing
- Retire sampled at edge N → HDR valid from cycle N+1 at the earliest. All outputs are registered.
- Back-to-back packets have no idle cycle. Throughput is 1 word/cycle with `i_tx_ready` held high.
- Sustained retirement of one per cycle with 3-word packets overflows after DEPTH records plus the in-flight one. This is by design.

## Configuration
- **`TRACE_STALL_EN` defined:**
  - `o_stall` equals the registered FIFO full flag.
  - The core is required to hold `i_retire_valid` low while stalled.
  - A retire while stalled is still dropped and counted.
- **`TRACE_STALL_EN` undefined:**
  - `o_stall` is tied 0.
  - Overflow is lossy and reported through drops.

## Structure
- **`trace_pkg` contents:**
  - `trace_rec_t` struct: pc, instr, rd_v, rd_addr, rd_data, mem_v, mem_addr, mem_wdata, seq, drops.
  - `TRACE_TAG` = 8'hA5.
  - Serializer state enum.
- **Sub-module `trace_fifo`:** synchronous FIFO of `trace_rec_t`, parameterized by DEPTH, with registered count and full/empty flags.
- **Top level:** the capture logic, counters and serializer FSM stay in `retire_trace_tx`.

## Test plan
- **Single retire, no writeback:** after reset, one retire with pc=0, instr=32'h00000013, rd_addr=0, rd_we=1, `i_tx_ready`=1.
  - 3 words: A5000000, 00000000, 00000013.
  - `o_tx_last` on word 3.
- **Full 6-word packet:** retire with rd=x5 / data 0x1234, store to 0x40 / data 0xDEADBEEF.
  - HDR 0xA500C500, then PC, INSTR, 00001234, 00000040, DEADBEEF.
  - `o_tx_last` on the 6th word only.
- **Backpressure:** `i_tx_ready` toggles 1,0,0,1 during a packet.
  - Data is held stable across the stalled cycles.
  - No duplicate or lost words.
- **Overflow (macro undefined):** DEPTH=4, `i_tx_ready`=0, 7 consecutive retires.
  - 5 records accepted (4 in FIFO, 1 in holding register).
  - After releasing ready, the next retire's HDR has [13]=1, drops=2, seq=7.
- **Stall (macro defined):** fill the FIFO.
  - `o_stall`=1 the cycle after the count reaches DEPTH.
  - Deasserts the cycle after the first pop.
- **Reset mid-packet:** assert `i_rst` while PC is being sent.
  - All outputs 0 immediately (asynchronous).
  - Next packet HDR is A5000000-form with seq=0.
